// File: rtl/priority_irq_pkg.sv
// Shared types and constants for the priority interrupt controller.
package priority_irq_pkg;
  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef logic [N_SRC-1:0] req_vec_t;
  typedef logic [ID_W-1:0]  irq_id_t;

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;
endpackage

// File: rtl/pri_enc8.sv
// Combinational 8:3 priority encoder, bit 7 highest.
module pri_enc8
  import priority_irq_pkg::*;
(
  input  req_vec_t vec,
  output irq_id_t  idx,
  output logic     any
);
  always_comb begin
    idx = '0;
    // Ascending scan: a later (higher) set bit overrides a lower one.
    for (int b = 0; b < N_SRC; b++)
      if (vec[b]) idx = irq_id_t'(b);
    any = |vec;
  end
endmodule

// File: rtl/priority_irq_ctrl.sv
// 8-source priority interrupt controller with present/accept/EOI handshake.
// Optional per-source mask input when IRQ_MASK_EN is defined.
module priority_irq_ctrl
  import priority_irq_pkg::*;
#(
  parameter int EDGE = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req,
`ifdef IRQ_MASK_EN
  input  req_vec_t mask,
`endif
  input  logic     irq_ready,
  input  logic     eoi,
  output logic     irq_valid,
  output irq_id_t  irq_id,
  output logic     busy,
  output req_vec_t pending
);
  state_t   state;
  req_vec_t req_s, req_q, capture, clr, eligible;
  logic [1:0] prime;
  irq_id_t  enc_idx;
  logic     enc_any;

  // req is registered once before edge detection; prime[1] marks req_q as
  // holding real post-reset samples so levels high at reset are not edges.
  always_comb begin
    capture = '0;
    if (EDGE != 0) begin
      if (prime[1]) capture = req_s & ~req_q;
    end else begin
      capture = req_s;
    end
  end

  always_comb begin
    clr = '0;
    if (irq_valid && irq_ready) clr[irq_id] = 1'b1;
  end

`ifdef IRQ_MASK_EN
  assign eligible = pending & ~mask;
`else
  assign eligible = pending;
`endif

  pri_enc8 u_enc (
    .vec (eligible),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_s     <= '0;
      req_q     <= '0;
      prime     <= '0;
      pending   <= '0;
      irq_id    <= '0;
      irq_valid <= 1'b0;
      busy      <= 1'b0;
      state     <= IDLE;
    end else begin
      req_s   <= req;
      req_q   <= req_s;
      prime   <= {prime[0], 1'b1};
      // New capture wins over the acceptance clear on the same bit.
      pending <= (pending & ~clr) | capture;
      case (state)
        IDLE: if (enc_any) begin
          state     <= PRESENT;
          irq_id    <= enc_idx;
          irq_valid <= 1'b1;
        end
        PRESENT: if (irq_ready) begin
          state     <= SERVICE;
          irq_valid <= 1'b0;
          busy      <= 1'b1;
        end
        SERVICE: if (eoi) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Directed scoreboard bench: one EDGE=1 instance and one EDGE=0 instance.
module tb_priority_irq_ctrl;
  import priority_irq_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  req_vec_t req  [2];
  logic     rdy  [2];
  logic     eoi  [2];
  logic     vld  [2];
  irq_id_t  id   [2];
  logic     busy [2];
  req_vec_t pend [2];
`ifdef IRQ_MASK_EN
  req_vec_t mask [2];
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  priority_irq_ctrl #(.EDGE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]),
`ifdef IRQ_MASK_EN
    .mask(mask[0]),
`endif
    .irq_ready(rdy[0]), .eoi(eoi[0]), .irq_valid(vld[0]), .irq_id(id[0]),
    .busy(busy[0]), .pending(pend[0]));

  priority_irq_ctrl #(.EDGE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]),
`ifdef IRQ_MASK_EN
    .mask(mask[1]),
`endif
    .irq_ready(rdy[1]), .eoi(eoi[1]), .irq_valid(vld[1]), .irq_id(id[1]),
    .busy(busy[1]), .pending(pend[1]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a presented ID and compare it against the scoreboard.
  task automatic wait_check(input int s, input string tag);
    int e;
    for (int i = 0; i < 12 && !vld[s]; i++) tick();
    chk({tag, "_valid"}, 32'(vld[s]), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    chk({tag, "_id"}, 32'(id[s]), 32'(e));
  endtask

  task automatic accept_eoi(input int s, input string tag);
    rdy[s] = 1'b1;
    tick();
    rdy[s] = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy[s]}, 32'd1);
    chk({tag, "_novalid"}, {31'd0, vld[s]}, 32'd0);
    eoi[s] = 1'b1;
    tick();
    eoi[s] = 1'b0;
    chk({tag, "_idle"}, {31'd0, busy[s]}, 32'd0);
  endtask

  initial begin
    int cnt;
    for (int s = 0; s < 2; s++) begin
      req[s] = '0; rdy[s] = 1'b0; eoi[s] = 1'b0;
`ifdef IRQ_MASK_EN
      mask[s] = '0;
`endif
    end
    rst_n = 1'b0;
    req[1] = 8'h10;               // level already high across reset release
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", {31'd0, vld[s]}, 32'd0);
      chk("rst_busy", {31'd0, busy[s]}, 32'd0);
      chk("rst_pend", 32'(pend[s]), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("no_edge_at_release", 32'(pend[1]), 32'd0);
    chk("no_valid_at_release", {31'd0, vld[1]}, 32'd0);
    req[1] = '0;
    tick(); tick();

    // 00 -> 24 held: latency, priority order, no re-trigger while held
    req[1] = 8'h24;
    exp_q.push_back(5); exp_q.push_back(2);
    tick();
    chk("lat_pend_k", 32'(pend[1]), 32'd0);
    tick();
    chk("lat_pend_k1", 32'(pend[1]), 32'h24);
    chk("lat_valid_k1", {31'd0, vld[1]}, 32'd0);
    tick();
    wait_check(1, "p24_a");
    accept_eoi(1, "p24_a");
    wait_check(1, "p24_b");
    accept_eoi(1, "p24_b");
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); cnt += int'(vld[1]); end
    chk("held_no_more", 32'(cnt), 32'd0);
    req[1] = '0;
    tick(); tick();

    // Stable ID while presenting despite higher-priority arrival
    exp_q.push_back(1); exp_q.push_back(7);
    req[1] = 8'h02; tick(); req[1] = '0;
    wait_check(1, "stab_1");
    req[1] = 8'h80; tick(); req[1] = '0;
    tick(); tick(); tick();
    chk("stab_id", 32'(id[1]), 32'd1);
    chk("stab_valid", {31'd0, vld[1]}, 32'd1);
    accept_eoi(1, "stab_1");
    wait_check(1, "stab_7");
    accept_eoi(1, "stab_7");

    // Capture and accept on the same bit in the same cycle
    exp_q.push_back(3); exp_q.push_back(3);
    req[1] = 8'h08; tick(); req[1] = '0;
    wait_check(1, "same_a");
    tick(); tick();
    req[1] = 8'h08; tick();        // capture is live during the accept edge
    rdy[1] = 1'b1; tick(); rdy[1] = 1'b0;
    req[1] = '0;
    chk("same_pend3", {31'd0, pend[1][3]}, 32'd1);
    eoi[1] = 1'b1; tick(); eoi[1] = 1'b0;
    wait_check(1, "same_b");
    accept_eoi(1, "same_b");

    // Reset while in service with pending 81
    exp_q.push_back(0);
    req[1] = 8'h01; tick(); req[1] = '0;
    wait_check(1, "rsv");
    rdy[1] = 1'b1; tick(); rdy[1] = 1'b0;
    req[1] = 8'h81; tick(); req[1] = '0; tick();
    chk("rsv_pend", 32'(pend[1]), 32'h81);
    chk("rsv_busy", {31'd0, busy[1]}, 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rsv_pend0", 32'(pend[1]), 32'd0);
    chk("rsv_busy0", {31'd0, busy[1]}, 32'd0);
    chk("rsv_valid0", {31'd0, vld[1]}, 32'd0);
    tick(); tick(); tick();

`ifdef IRQ_MASK_EN
    // Masked source captured but not presented until unmasked
    exp_q.push_back(0); exp_q.push_back(7);
    mask[1] = 8'h80;
    req[1] = 8'h81; tick(); req[1] = '0;
    wait_check(1, "mask_0");
    accept_eoi(1, "mask_0");
    mask[1] = '0;
    wait_check(1, "mask_7");
    accept_eoi(1, "mask_7");
`endif

    // Level mode: held request re-presents after each service
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
    req[0] = 8'h10;
    wait_check(0, "lvl_a");
    accept_eoi(0, "lvl_a");
    wait_check(0, "lvl_b");
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    chk("lvl_repend", {31'd0, pend[0][4]}, 32'd1);
    eoi[0] = 1'b1; tick(); eoi[0] = 1'b0;
    wait_check(0, "lvl_c");
    req[0] = '0; tick(); tick();
    accept_eoi(0, "lvl_c");
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); cnt += int'(vld[0]); end
    chk("lvl_quiet", 32'(cnt), 32'd0);
    chk("lvl_pend0", 32'(pend[0]), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
